writeback_cycle: RTL and testbench

//  M->W stage: finishes the instruction leaving execute and owns the register-file write port
//  (RegWriteW/RDW/ResultW) that decode_cycle reads from.

---
 rtl/writeback_cycle_pkg.sv | 27 ++
 rtl/writeback_cycle_mem_access_ctrl.sv | 96 +++++++++
 rtl/writeback_cycle.sv | 84 ++++++++
 tb/tb_writeback_cycle.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_cycle_pkg.sv
`default_nettype none
// ============================================================================
// Module  : writeback_cycle_pkg
// Brief   : Shared types and constants for the M->W write-back stage.
// Revision: 1.0 - initial release
// ============================================================================
package writeback_cycle_pkg;

    localparam int c_DATA_W = 32;

    localparam logic c_RESULT_ALU = 1'b0;
    localparam logic c_RESULT_MEM = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } memState_t;

    // Any valid load or store needs the data-memory port.
    function automatic logic isMemOp(input logic valid, input logic memWrite,
                                     input logic resultSrc);
        return valid & (memWrite | (resultSrc == c_RESULT_MEM));
    endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_cycle_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : writeback_cycle_mem_access_ctrl
// Brief   : Data-memory handshake FSM with timeout, stall generation and load capture.
// Revision: 1.0 - initial release
// ============================================================================
module writeback_cycle_mem_access_ctrl
    import writeback_cycle_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memOp,
    input  logic              memWrite,
    input  logic              isLoad,
    input  logic [DATA_W-1:0] addrIn,
    input  logic [DATA_W-1:0] wdataIn,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              dmem_err,
    output logic [DATA_W-1:0] loadData
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    memState_t          r_state;
    memState_t          w_next;
    logic [CNT_W-1:0]   r_count;
    logic               w_timeout;

    // Ack takes priority over an expiring counter in the same cycle.
    assign w_timeout = (r_state == ACCESS) && !dmem_ack
                       && (r_count == CNT_W'(TIMEOUT - 1));
    assign stall     = ((r_state == IDLE) && memOp) || (r_state == ACCESS);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (memOp) w_next = ACCESS;
            ACCESS:  if (dmem_ack || w_timeout) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_err   <= 1'b0;
            loadData   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (memOp) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= memWrite;
                        dmem_addr  <= ADDR_W'(addrIn);
                        dmem_wdata <= wdataIn;
                        r_count    <= '0;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (isLoad) loadData <= dmem_rdata;
                    end else if (w_timeout) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        dmem_err <= 1'b1;
                        loadData <= '0;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/writeback_cycle.sv
`default_nettype none
// ============================================================================
// Module  : writeback_cycle
// Brief   : M->W stage: data-memory access, W pipeline register and result mux.
// Revision: 1.0 - initial release
// ============================================================================
module writeback_cycle
    import writeback_cycle_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ValidM,
    input  logic              RegWriteM,
    input  logic              ResultSrcM,
    input  logic              MemWriteM,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [4:0]        RDM,
    output logic              StallM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              dmem_err,
    output logic              RegWriteW,
    output logic [4:0]        RDW,
    output logic [DATA_W-1:0] ResultW
);

    logic              w_memOp;
    logic              w_regWrite;
    logic [DATA_W-1:0] w_loadData;
    logic [DATA_W-1:0] w_result;

    assign w_memOp    = isMemOp(ValidM, MemWriteM, ResultSrcM);
    // Stores and x0 destinations never reach the register file.
    assign w_regWrite = ValidM & RegWriteM & ~MemWriteM & (RDM != 5'd0);
    assign w_result   = (ResultSrcM == c_RESULT_MEM) ? w_loadData : ALUResultM;

    writeback_cycle_mem_access_ctrl #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) u_memAccessCtrl (
        .clk        (clk),
        .rst        (rst),
        .memOp      (w_memOp),
        .memWrite   (MemWriteM),
        .isLoad     (ResultSrcM),
        .addrIn     (ALUResultM),
        .wdataIn    (WriteDataM),
        .stall      (StallM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .dmem_err   (dmem_err),
        .loadData   (w_loadData)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW <= 1'b0;
            RDW       <= '0;
            ResultW   <= '0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
        end else begin
            RegWriteW <= w_regWrite;
            RDW       <= RDM;
            ResultW   <= w_result;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_cycle.sv
`default_nettype none
// ============================================================================
// Module  : tb_writeback_cycle
// Brief   : Scoreboard bench for writeback_cycle with a directed memory responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_writeback_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ValidM = 1'b0, RegWriteM = 1'b0, ResultSrcM = 1'b0, MemWriteM = 1'b0;
    logic [31:0] ALUResultM = '0, WriteDataM = '0;
    logic [4:0]  RDM = '0;
    logic        StallM, dmem_req, dmem_we, dmem_err, RegWriteW;
    logic [31:0] dmem_addr, dmem_wdata, ResultW;
    logic [31:0] dmem_rdata = 32'hBAD0_BAD0;
    logic        dmem_ack = 1'b0;
    logic [4:0]  RDW;

    writeback_cycle #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .ValidM(ValidM), .RegWriteM(RegWriteM),
        .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .RDM(RDM), .StallM(StallM), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    typedef struct { logic [4:0] rd; logic [31:0] data; } exp_t;
    exp_t sbq[$];
    exp_t monE;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ackDelay request cycles unless ackNever.
    int          ackDelay = 0;
    bit          ackNever = 1'b0;
    logic [31:0] rdataVal = '0;
    int          reqCnt = 0, reqCycles = 0, weCycles = 0;
    logic [31:0] lastAddr = '0, lastWdata = '0;

    always @(negedge clk) begin
        if (dmem_req) begin
            reqCycles++;
            if (dmem_we) weCycles++;
            lastAddr  = dmem_addr;
            lastWdata = dmem_wdata;
            if (!ackNever && reqCnt == ackDelay) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdataVal;
            end else begin
                dmem_ack   = 1'b0;
                dmem_rdata = 32'hBAD0_BAD0;
            end
            reqCnt++;
        end else begin
            dmem_ack   = 1'b0;
            dmem_rdata = 32'hBAD0_BAD0;
            reqCnt     = 0;
        end
    end

    // Monitor: every register-file write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && RegWriteW) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%08h, expected no write", RDW, ResultW);
            end else begin
                monE = sbq.pop_front();
                check("wb_rd", 32'(RDW), 32'(monE.rd));
                check("wb_data", ResultW, monE.data);
            end
        end
    end

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.rd = rd;
        e.data = data;
        sbq.push_back(e);
    endtask

    // Present one instruction at posedge+1; returns once it has committed.
    task automatic issue(input logic rw, input logic rsrc, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                         output int stalls, output int commitCycle);
        ValidM = 1'b1; RegWriteM = rw; ResultSrcM = rsrc; MemWriteM = mw;
        ALUResultM = alu; WriteDataM = wd; RDM = rd;
        stalls = 0;
        @(negedge clk);
        while (StallM && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL stall_bound: got StallM stuck for %0d cycles, expected release", stalls);
        end
        @(posedge clk);
        #1;
        commitCycle = cycle;
        ValidM = 1'b0; RegWriteM = 1'b0; ResultSrcM = 1'b0; MemWriteM = 1'b0;
    endtask

    int st, c1, c2;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(dmem_req), 0);
        check("rst_regwrite", 32'(RegWriteW), 0);
        check("rst_rdw", 32'(RDW), 0);
        check("rst_result", ResultW, 0);
        check("rst_err", 32'(dmem_err), 0);
        check("rst_stall", 32'(StallM), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // ALU op: one-edge latency, no stall
        push(5'd5, 32'h0000_1234);
        issue(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, st, c1);
        check("alu_stall", st, 0);
        check("alu_regwrite", 32'(RegWriteW), 1);

        // Load with one wait cycle: StallM for IDLE + 2 ACCESS cycles
        ackDelay = 1; rdataVal = 32'hDEAD_BEEF; reqCycles = 0;
        push(5'd9, 32'hDEAD_BEEF);
        issue(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd9, st, c1);
        check("load_stall", st, 3);
        check("load_addr", lastAddr, 32'h0000_0100);
        check("load_reqcycles", reqCycles, 2);
        check("load_req_after", 32'(dmem_req), 0);
        check("load_regwrite", 32'(RegWriteW), 1);
        @(posedge clk); #1;
        check("load_pulse", 32'(RegWriteW), 0);

        // Store with immediate ack, RegWriteM asserted but must not write
        ackDelay = 0; reqCycles = 0; weCycles = 0;
        issue(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 5'd3, st, c1);
        check("store_stall", st, 2);
        check("store_we_cycles", weCycles, 1);
        check("store_req_cycles", reqCycles, 1);
        check("store_addr", lastAddr, 32'h0000_0040);
        check("store_wdata", lastWdata, 32'hA5A5_A5A5);
        check("store_regwrite", 32'(RegWriteW), 0);

        // Write to x0 is suppressed
        issue(1'b1, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0, 5'd0, st, c1);
        check("x0_stall", st, 0);
        check("x0_regwrite", 32'(RegWriteW), 0);

        // Back-to-back load then ALU op
        ackDelay = 0; rdataVal = 32'h1111_2222;
        push(5'd10, 32'h1111_2222);
        push(5'd11, 32'h0000_0055);
        issue(1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 5'd10, st, c1);
        check("b2b_load_stall", st, 2);
        issue(1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 5'd11, st, c2);
        check("b2b_alu_stall", st, 0);
        check("b2b_commit_gap", c2 - c1, 1);

        // Load that is never acked: forced completion after 16 ACCESS cycles
        ackNever = 1'b1;
        push(5'd7, 32'h0);
        issue(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 5'd7, st, c1);
        check("timeout_stall", st, 17);
        check("timeout_err", 32'(dmem_err), 1);
        ackNever = 1'b0;
        push(5'd12, 32'h0000_0077);
        issue(1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd12, st, c1);
        check("resume_stall", st, 0);
        check("err_sticky", 32'(dmem_err), 1);

        // Asynchronous reset while a load is outstanding
        ackNever = 1'b1;
        ValidM = 1'b1; RegWriteM = 1'b1; ResultSrcM = 1'b1; MemWriteM = 1'b0;
        ALUResultM = 32'h0000_0300; RDM = 5'd4;
        repeat (3) @(posedge clk);
        #2;
        check("mid_req_open", 32'(dmem_req), 1);
        rst = 1'b0;
        #1;
        check("mid_req_drop", 32'(dmem_req), 0);
        check("mid_regwrite", 32'(RegWriteW), 0);
        check("mid_err_clear", 32'(dmem_err), 0);
        ValidM = 1'b0; RegWriteM = 1'b0; ResultSrcM = 1'b0;
        ackNever = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_stall", 32'(StallM), 0);
        check("post_rst_req", 32'(dmem_req), 0);
        @(posedge clk); #1;
        push(5'd13, 32'h0000_0ABC);
        issue(1'b1, 1'b0, 1'b0, 32'h0000_0ABC, 32'h0, 5'd13, st, c1);
        check("post_rst_alu_stall", st, 0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
